// File: rtl/rv32ima_pkg.sv
// Shared RV32IMA core types and constants.
// Holds the fetch FSM state encoding and the canonical NOP word.
package rv32ima_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    // addi x0, x0, 0
    localparam word_t NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN,
        HOLD
    } fetch_state_t;

endpackage

// File: rtl/fetch_if.sv
// Bundle of fetch-stage signals with views for the fetch unit,
// instruction memory and datapath.
interface fetch_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic [ADDR_W-1:0] curr_pc;
    logic              next_pc_en;
    logic              inst_ready;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;
    logic              inst_valid;
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              dp_ready;
    logic              flush;

    modport fetch (
        input  curr_pc, next_pc_en, imem_ack, imem_rdata, dp_ready, flush,
        output inst_ready, imem_req, imem_addr, inst_valid, inst, inst_pc
    );

    modport imem (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata
    );

    modport dp (
        input  inst_valid, inst, inst_pc,
        output dp_ready, flush
    );

endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: req/ack handshake to imem, holds the word until the
// datapath takes it. Define FETCH_MISALIGN_CHECK_EN to trap misaligned PCs.
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_INST = rv32ima_pkg::NOP_INST
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [ADDR_W-1:0] curr_pc,
    input  logic              next_pc_en,
    output logic              inst_ready,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic              inst_fault,
`endif
    input  logic              dp_ready,
    input  logic              flush
);

    import rv32ima_pkg::*;

    fetch_state_t      state_q,    state_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [DATA_W-1:0] inst_q,     inst_d;
    logic [ADDR_W-1:0] inst_pc_q,  inst_pc_d;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic fault_q, fault_d;
    logic misaligned;

    assign misaligned = |curr_pc[1:0];
`else
    logic pc_lsbs_unused;

    assign pc_lsbs_unused = ^curr_pc[1:0];
`endif

    // NOTE: every variable is given its hold value before the case, so no
    // path through this block leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        inst_ready = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        fault_d    = fault_q;
`endif

        case (state_q)
            IDLE: begin
                if (next_pc_en) begin
`ifdef FETCH_MISALIGN_CHECK_EN
                    if (misaligned) begin
                        state_d   = HOLD;
                        inst_d    = NOP_INST;
                        inst_pc_d = curr_pc;
                        fault_d   = 1'b1;
                    end else
`endif
                    begin
                        req_addr_d = {curr_pc[ADDR_W-1:2], 2'b00};
                        state_d    = REQ;
                    end
                end
            end

            REQ: begin
                if (imem_ack) begin
                    if (flush) begin
                        inst_ready = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        inst_d    = imem_rdata;
                        inst_pc_d = req_addr_q;
                        state_d   = HOLD;
                    end
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end

            // The request cannot be withdrawn; wait for its ack and drop the word.
            DRAIN: begin
                if (imem_ack) begin
                    inst_ready = 1'b1;
                    state_d    = IDLE;
                end
            end

            HOLD: begin
                if (dp_ready || flush) begin
                    inst_ready = 1'b1;
                    state_d    = IDLE;
`ifdef FETCH_MISALIGN_CHECK_EN
                    fault_d    = 1'b0;
`endif
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q    <= IDLE;
            req_addr_q <= '0;
            inst_q     <= NOP_INST;
            inst_pc_q  <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            fault_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
`ifdef FETCH_MISALIGN_CHECK_EN
            fault_q    <= fault_d;
`endif
        end
    end

    assign imem_req   = (state_q == REQ) || (state_q == DRAIN);
    assign imem_addr  = req_addr_q;
    assign inst_valid = (state_q == HOLD);
    assign inst       = inst_valid ? inst_q : NOP_INST;
    assign inst_pc    = inst_pc_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    assign inst_fault = fault_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written
// reset/alignment sequences, then randomized traffic against a queue model.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        nrst;
    logic [31:0] curr_pc;
    logic        next_pc_en;
    logic        inst_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        dp_ready;
    logic        flush;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        inst_fault;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .NOP_INST (NOP)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .curr_pc    (curr_pc),
        .next_pc_en (next_pc_en),
        .inst_ready (inst_ready),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
`ifdef FETCH_MISALIGN_CHECK_EN
        .inst_fault (inst_fault),
`endif
        .dp_ready   (dp_ready),
        .flush      (flush)
    );

    typedef struct {
        logic        en;
        logic [31:0] pc;
        logic        ack;
        logic [31:0] rdata;
        logic        dp;
        logic        fl;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        logic        e_rdy;
    } vec_t;

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
    } held_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic en, input logic [31:0] pc, input logic ack,
                               input logic [31:0] rdata, input logic dp, input logic fl,
                               input logic e_req, input logic [31:0] e_addr,
                               input logic e_valid, input logic [31:0] e_inst,
                               input logic [31:0] e_pc, input logic e_rdy);
        vec_t r;
        r.en = en; r.pc = pc; r.ack = ack; r.rdata = rdata; r.dp = dp; r.fl = fl;
        r.e_req = e_req; r.e_addr = e_addr; r.e_valid = e_valid;
        r.e_inst = e_inst; r.e_pc = e_pc; r.e_rdy = e_rdy;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic en, input logic [31:0] pc, input logic ack,
                         input logic [31:0] rdata, input logic dp, input logic fl);
        next_pc_en = en;
        curr_pc    = pc;
        imem_ack   = ack;
        imem_rdata = rdata;
        dp_ready   = dp;
        flush      = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        apply(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        nrst = 1'b1;
        apply(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".req"},   {31'h0, imem_req},   32'h0);
        check({tag, ".valid"}, {31'h0, inst_valid}, 32'h0);
        check({tag, ".inst"},  inst,                NOP);
        check({tag, ".ready"}, {31'h0, inst_ready}, 32'h0);
    endtask

    initial begin
        logic [31:0] pend_q[$];
        held_t       held_q[$];
        bit          killed;

        // Basic fetch with zero-wait ack and immediate accept.
        vecs.push_back(v(1, 32'h100, 0, 32'h0,        0, 0,  0, 32'h0,   0, NOP,          32'h0,   0));
        vecs.push_back(v(0, 32'h0,   1, 32'h00500093, 0, 0,  1, 32'h100, 0, NOP,          32'h0,   0));
        vecs.push_back(v(0, 32'h0,   0, 32'h0,        1, 0,  0, 32'h0,   1, 32'h00500093, 32'h100, 1));
        vecs.push_back(v(0, 32'h0,   0, 32'h0,        0, 0,  0, 32'h0,   0, NOP,          32'h0,   0));
        // Three-cycle ack with curr_pc moving underneath the request.
        vecs.push_back(v(1, 32'h200, 0, 32'h0,        0, 0,  0, 32'h0,   0, NOP,          32'h0,   0));
        vecs.push_back(v(1, 32'h300, 0, 32'h0,        0, 0,  1, 32'h200, 0, NOP,          32'h0,   0));
        vecs.push_back(v(1, 32'h304, 0, 32'h0,        0, 0,  1, 32'h200, 0, NOP,          32'h0,   0));
        vecs.push_back(v(1, 32'h308, 1, 32'h11111111, 0, 0,  1, 32'h200, 0, NOP,          32'h0,   0));
        // Four stalled cycles in HOLD, a stray ack among them, then accept.
        vecs.push_back(v(1, 32'h30C, 0, 32'h0,        0, 0,  0, 32'h0,   1, 32'h11111111, 32'h200, 0));
        vecs.push_back(v(1, 32'h30C, 1, 32'hFFFFFFFF, 0, 0,  0, 32'h0,   1, 32'h11111111, 32'h200, 0));
        vecs.push_back(v(1, 32'h30C, 0, 32'h0,        0, 0,  0, 32'h0,   1, 32'h11111111, 32'h200, 0));
        vecs.push_back(v(1, 32'h30C, 0, 32'h0,        0, 0,  0, 32'h0,   1, 32'h11111111, 32'h200, 0));
        vecs.push_back(v(0, 32'h0,   0, 32'h0,        1, 0,  0, 32'h0,   1, 32'h11111111, 32'h200, 1));
        vecs.push_back(v(0, 32'h0,   0, 32'h0,        0, 0,  0, 32'h0,   0, NOP,          32'h0,   0));
        // Flush in REQ, ack two cycles later is dropped.
        vecs.push_back(v(1, 32'h400, 0, 32'h0,        0, 0,  0, 32'h0,   0, NOP,          32'h0,   0));
        vecs.push_back(v(0, 32'h0,   0, 32'h0,        0, 1,  1, 32'h400, 0, NOP,          32'h0,   0));
        vecs.push_back(v(0, 32'h0,   0, 32'h0,        0, 0,  1, 32'h400, 0, NOP,          32'h0,   0));
        vecs.push_back(v(0, 32'h0,   1, 32'hDEADBEEF, 0, 0,  1, 32'h400, 0, NOP,          32'h0,   1));
        vecs.push_back(v(0, 32'h0,   0, 32'h0,        1, 0,  0, 32'h0,   0, NOP,          32'h0,   0));
        // Flush coinciding with ack, then a stray ack while idle.
        vecs.push_back(v(1, 32'h500, 0, 32'h0,        0, 0,  0, 32'h0,   0, NOP,          32'h0,   0));
        vecs.push_back(v(0, 32'h0,   1, 32'h22222222, 0, 1,  1, 32'h500, 0, NOP,          32'h0,   1));
        vecs.push_back(v(0, 32'h0,   1, 32'h33333333, 1, 0,  0, 32'h0,   0, NOP,          32'h0,   0));
        // Flush and dp_ready together in HOLD give one pulse.
        vecs.push_back(v(1, 32'h600, 0, 32'h0,        0, 0,  0, 32'h0,   0, NOP,          32'h0,   0));
        vecs.push_back(v(0, 32'h0,   1, 32'h44444444, 0, 0,  1, 32'h600, 0, NOP,          32'h0,   0));
        vecs.push_back(v(0, 32'h0,   0, 32'h0,        1, 1,  0, 32'h0,   1, 32'h44444444, 32'h600, 1));
        vecs.push_back(v(0, 32'h0,   0, 32'h0,        0, 0,  0, 32'h0,   0, NOP,          32'h0,   0));

        do_reset();
        check_idle("rst");
        check("rst.addr", imem_addr, 32'h0);
        check("rst.pc",   inst_pc,   32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("rst.fault", {31'h0, inst_fault}, 32'h0);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].en, vecs[i].pc, vecs[i].ack, vecs[i].rdata, vecs[i].dp, vecs[i].fl);
            check($sformatf("v%0d.req", i),   {31'h0, imem_req},   {31'h0, vecs[i].e_req});
            check($sformatf("v%0d.valid", i), {31'h0, inst_valid}, {31'h0, vecs[i].e_valid});
            check($sformatf("v%0d.inst", i),  inst,                vecs[i].e_inst);
            check($sformatf("v%0d.ready", i), {31'h0, inst_ready}, {31'h0, vecs[i].e_rdy});
            if (vecs[i].e_req)
                check($sformatf("v%0d.addr", i), imem_addr, vecs[i].e_addr);
            if (vecs[i].e_valid)
                check($sformatf("v%0d.ipc", i), inst_pc, vecs[i].e_pc);
            tick();
        end

        // Reset for one edge while a request is outstanding.
        apply(1'b1, 32'h800, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        apply(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("mid.req", {31'h0, imem_req}, 32'h1);
        check("mid.addr", imem_addr, 32'h800);
        do_reset();
        check_idle("midrst");
        check("midrst.addr", imem_addr, 32'h0);

`ifdef FETCH_MISALIGN_CHECK_EN
        apply(1'b1, 32'h102, 1'b0, 32'h0, 1'b0, 1'b0);
        check("mis.req0", {31'h0, imem_req}, 32'h0);
        tick();
        apply(1'b0, 32'h0, 1'b1, 32'hABCDABCD, 1'b0, 1'b0);
        check("mis.req1",  {31'h0, imem_req},   32'h0);
        check("mis.valid", {31'h0, inst_valid}, 32'h1);
        check("mis.fault", {31'h0, inst_fault}, 32'h1);
        check("mis.inst",  inst,                NOP);
        check("mis.pc",    inst_pc,             32'h102);
        check("mis.rdy0",  {31'h0, inst_ready}, 32'h0);
        apply(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("mis.rdy1",  {31'h0, inst_ready}, 32'h1);
        tick();
        apply(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("mis.fault_clr", {31'h0, inst_fault}, 32'h0);
        check_idle("mis.after");
`else
        // Without the check the low PC bits are dropped from the request.
        apply(1'b1, 32'h702, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        apply(1'b0, 32'h0, 1'b1, 32'h55555555, 1'b0, 1'b0);
        check("drop.req",  {31'h0, imem_req}, 32'h1);
        check("drop.addr", imem_addr, 32'h700);
        tick();
        apply(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("drop.inst", inst,    32'h55555555);
        check("drop.pc",   inst_pc, 32'h700);
        check("drop.rdy",  {31'h0, inst_ready}, 32'h1);
        tick();
`endif

        // Randomized traffic against a transaction-level model.
        do_reset();
        killed = 1'b0;
        for (int c = 0; c < 600; c++) begin
            logic        en, ack, dp, fl, e_req, e_valid, e_rdy;
            logic [31:0] pc, rd;
            en = ($urandom_range(0, 9) < 7);
            pc = $urandom;
`ifdef FETCH_MISALIGN_CHECK_EN
            pc[1:0] = 2'b00;
`endif
            ack = ($urandom_range(0, 9) < 4);
            rd  = $urandom;
            dp  = ($urandom_range(0, 9) < 4);
            fl  = ($urandom_range(0, 9) < 2);
            apply(en, pc, ack, rd, dp, fl);

            e_req   = (pend_q.size() != 0);
            e_valid = (held_q.size() != 0);
            e_rdy   = (e_req && ack && (killed || fl)) || (e_valid && (dp || fl));

            check($sformatf("r%0d.req", c),   {31'h0, imem_req},   {31'h0, e_req});
            check($sformatf("r%0d.valid", c), {31'h0, inst_valid}, {31'h0, e_valid});
            check($sformatf("r%0d.ready", c), {31'h0, inst_ready}, {31'h0, e_rdy});
            check($sformatf("r%0d.inst", c),  inst, e_valid ? held_q[0].word : NOP);
            if (e_req)
                check($sformatf("r%0d.addr", c), imem_addr, pend_q[0]);
            if (e_valid)
                check($sformatf("r%0d.ipc", c), inst_pc, held_q[0].pc);
`ifdef FETCH_MISALIGN_CHECK_EN
            check($sformatf("r%0d.fault", c), {31'h0, inst_fault}, 32'h0);
`endif

            if (e_valid) begin
                if (dp || fl)
                    held_q.delete();
            end else if (e_req) begin
                if (ack) begin
                    if (!(killed || fl))
                        held_q.push_back('{word: rd, pc: pend_q[0]});
                    pend_q.delete();
                end else if (fl) begin
                    killed = 1'b1;
                end
            end else if (en) begin
                pend_q.push_back({pc[31:2], 2'b00});
                killed = 1'b0;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Takes the current PC and runs a req/ack handshake with instruction memory.
- Holds the returned word until the datapath accepts it.
- Pulses inst_ready back to the PC so the PC advances exactly once per delivered (or flushed) instruction.

Parameters:
- ADDR_W, 32, instruction address width.
- DATA_W, 32, instruction word width.
- NOP_INST, 32'h0000_0013, word driven on inst when no valid instruction is held (addi x0,x0,0).

Ports:
- clk  in  1  clock.
- nrst  in  1  synchronous active-low reset.
- curr_pc  in  ADDR_W  PC of the instruction to fetch.
- next_pc_en  in  1  PC requests fetching; a request starts only when high.
- inst_ready  out  1  one-cycle pulse: current instruction consumed or flushed; PC loads next_pc.
- imem_req  out  1  memory request valid.
- imem_addr  out  ADDR_W  request address; stable while imem_req high.
- imem_ack  in  1  memory response valid; imem_rdata sampled this cycle.
- imem_rdata  in  DATA_W  instruction word.
- inst_valid  out  1  inst/inst_pc hold a valid instruction.
- inst  out  DATA_W  instruction to the datapath.
- inst_pc  out  ADDR_W  PC of inst.
- dp_ready  in  1  datapath accepts inst this cycle when inst_valid=1.
- flush  in  1  kill the held or in-flight instruction (branch taken).

Behaviour:
- All state updates on posedge clk only. nrst=0 at a clock edge puts the block in IDLE and clears all registers; reset mid-handshake abandons the request.
- Reset values: imem_req=0, imem_addr=0, inst_valid=0, inst=NOP_INST, inst_pc=0, inst_ready=0.
- States:
  - IDLE: if next_pc_en=1, latch req_addr<=curr_pc and go to REQ. There is no request in the IDLE cycle itself, so latency is 1 cycle from IDLE to imem_req=1.
  - REQ: imem_req=1, imem_addr=req_addr. curr_pc changes are ignored.
    - On imem_ack=1: latch inst<=imem_rdata, inst_pc<=req_addr, go to HOLD. Zero-wait-state memory gives inst_valid 2 cycles after IDLE.
    - If flush=1 and imem_ack=0: go to DRAIN.
    - If flush=1 and imem_ack=1 in the same cycle: discard the word, pulse inst_ready, go to IDLE.
  - DRAIN: imem_req held at 1 with the same address. On imem_ack, discard rdata, pulse inst_ready, go to IDLE. No inst_valid is ever produced from a drained request.
  - HOLD: inst_valid=1.
    - If dp_ready=1 or flush=1: pulse inst_ready for that cycle, clear inst_valid, go to IDLE. flush and dp_ready together count as one pulse.
    - Otherwise hold inst and inst_pc stable.
- inst_ready is combinational from state and inputs. There is at most one pulse per request, and never two cycles in a row.
- inst=NOP_INST whenever inst_valid=0.
- imem_addr[1:0] is always driven 0.
- imem_ack outside REQ/DRAIN is ignored.

Optional Feature:
- FETCH_MISALIGN_CHECK_EN defined:
  - Adds output inst_fault (1 bit, reset 0).
  - In IDLE with next_pc_en=1 and curr_pc[1:0]!=0: issue no memory request and go directly to HOLD with inst_valid=1, inst_fault=1, inst=NOP_INST, inst_pc=curr_pc.
  - inst_fault clears when the instruction leaves HOLD.
- FETCH_MISALIGN_CHECK_EN undefined: no inst_fault port; curr_pc[1:0] is silently dropped.

Decomposition:
- Package rv32ima_pkg (existing): word_t; add fetch_state_t enum {IDLE, REQ, DRAIN, HOLD}; add NOP_INST constant.
- Interface fetch_if in include/fetch_if.svh, with modports fetch, imem, and dp.
- No sub-module: one FSM plus the instruction/PC holding registers.

Test Plan:
- Reset then next_pc_en=1, curr_pc=0x100, imem_ack same cycle as req with rdata=0x00500093, dp_ready=1:
  - imem_addr=0x100.
  - inst_valid with inst=0x00500093, inst_pc=0x100.
  - inst_ready pulses once.
- 3-cycle ack latency with curr_pc changing during REQ: imem_addr stays 0x100 throughout; inst_pc=0x100.
- HOLD with dp_ready=0 for 4 cycles, then 1: inst stable for 4 cycles, inst_ready=0 until the accept cycle, then a single pulse.
- flush asserted in REQ, ack 2 cycles later with rdata=0xDEADBEEF: inst_valid never rises, one inst_ready pulse on the ack cycle, back to IDLE.
- nrst=0 for one edge while in REQ: next cycle imem_req=0, inst_valid=0, inst=0x00000013.
- With FETCH_MISALIGN_CHECK_EN and curr_pc=0x102: no imem_req; inst_valid=1, inst_fault=1, inst_pc=0x102.
